muldiv_unit: RTL

- Parametrised iterative multiply/divide unit with HI/LO result registers.
- Sits beside the combinational ALU in the EX stage of the pipeline.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in a single cycle.
- The pipeline controller stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit with HI/LO result registers. Sits beside the
//   EX-stage ALU. MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles: WIDTH
//   iterations plus one sign-correction/write-back cycle. MTHI/MTLO write a
//   result register in a single cycle and never raise busy or done.
//
//   Ports
//     clk          clock, all state changes on its rising edge
//     rst_n        asynchronous active-low reset
//     start        operation request, sampled only while not busy
//     op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                  110/111 reserved (ignored)
//     a            rs operand (multiplicand / dividend / MTHI-MTLO source)
//     b            rt operand (multiplier / divisor)
//     flush        abort any in-flight operation; beats start in IDLE
//     busy         high while an iterative operation is in progress
//     done         one-cycle pulse when hi/lo take a multi-cycle result
//     div_by_zero  one-cycle pulse with done for DIV/DIVU with b == 0
//     hi, lo       HI and LO result registers
//
//   Parameter constraint: 2**CNT_W must be greater than WIDTH.
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0]       OP_MTHI   = 3'b100;
   localparam logic [2:0]       OP_MTLO   = 3'b101;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Shared accumulator: for multiply, upper half = partial product and lower
   // half = multiplier being shifted out; for divide, upper half = partial
   // remainder and lower half = dividend shifting out / quotient shifting in.
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   opnd_reg;     // multiplicand or divisor magnitude
   logic [CNT_W-1:0]   cnt_reg;
   logic               is_div_reg;
   logic               neg_lo_reg;   // product / quotient needs negation
   logic               neg_hi_reg;   // remainder needs negation
   logic               dbz_reg;      // divide by zero detected at accept
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic               done_reg, dbz_out_reg;

   // ---------------------------------------------------------------- decode
   logic             op_is_iter, op_is_div, op_is_signed, b_is_zero;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign op_is_iter   = ~op[2];
   assign op_is_div    = op[1];
   assign op_is_signed = ~op[0];
   assign b_is_zero    = (b == '0);
   assign a_neg        = op_is_signed & a[WIDTH-1];
   assign b_neg        = op_is_signed & b[WIDTH-1];
   // -2^(W-1) maps onto itself, which reads correctly as an unsigned magnitude.
   assign a_abs        = a_neg ? -a : a;
   assign b_abs        = b_neg ? -b : b;

   // --------------------------------------------------------- control strobes
   logic accept, calc_step, finish_wr, mthi_wr, mtlo_wr;

   // ------------------------------------------------------------ state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               // A zero divisor has nothing to iterate on: report it at once.
               state_next = (op_is_div && b_is_zero) ? FINISH : CALC;
            end
         end
         CALC: begin
            if (flush) begin
               state_next = IDLE;
            end else if (cnt_reg == LAST_ITER) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ FSM outputs
   always_comb begin
      busy      = (state_reg != IDLE);
      accept    = (state_reg == IDLE) & start & ~flush & op_is_iter;
      mthi_wr   = (state_reg == IDLE) & start & ~flush & (op == OP_MTHI);
      mtlo_wr   = (state_reg == IDLE) & start & ~flush & (op == OP_MTLO);
      calc_step = (state_reg == CALC) & ~flush;
      finish_wr = (state_reg == FINISH) & ~flush;
   end

   // ------------------------------------------------------------ iteration step
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_step, div_step;

   always_comb begin
      // Shift-add: add multiplicand when the multiplier LSB is set, then shift
      // the whole accumulator right, keeping the carry as the new top bit.
      mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
               + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
      mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

      // Restoring divide: bring down the next dividend bit and trial-subtract.
      // No borrow means the subtraction sticks and the quotient bit is 1.
      div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {1'b0, opnd_reg};
      if (!div_trial[WIDTH]) begin
         div_step = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      end else begin
         div_step = {acc_reg[2*WIDTH-2:0], 1'b0};
      end
   end

   // ------------------------------------------------------------ sign fix-up
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

   always_comb begin
      prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
      quo_fix  = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      rem_fix  = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
      res_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];
   end

   // ------------------------------------------------------------ datapath regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         opnd_reg   <= '0;
         cnt_reg    <= '0;
         is_div_reg <= 1'b0;
         neg_lo_reg <= 1'b0;
         neg_hi_reg <= 1'b0;
         dbz_reg    <= 1'b0;
      end else if (accept) begin
         // Multiply iterates over b, divide shifts a out of the lower half.
         acc_reg    <= op_is_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
         opnd_reg   <= op_is_div ? b_abs : a_abs;
         cnt_reg    <= '0;
         is_div_reg <= op_is_div;
         neg_lo_reg <= a_neg ^ b_neg;
         neg_hi_reg <= a_neg;
         dbz_reg    <= op_is_div & b_is_zero;
      end else if (state_reg == CALC) begin
         if (calc_step) begin
            acc_reg <= is_div_reg ? div_step : mul_step;
         end
         // Counter returns to zero whenever CALC is left.
         if (flush || cnt_reg == LAST_ITER) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ HI / LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else begin
         if (finish_wr && !dbz_reg) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
         end
         if (mthi_wr) begin
            hi_reg <= a;
         end
         if (mtlo_wr) begin
            lo_reg <= a;
         end
      end
   end

   // ------------------------------------------------------------ status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_reg    <= 1'b0;
         dbz_out_reg <= 1'b0;
      end else begin
         done_reg    <= finish_wr;
         dbz_out_reg <= finish_wr & dbz_reg;
      end
   end

   assign done        = done_reg;
   assign div_by_zero = dbz_out_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule
